// File: rtl/int_seq.sv
// Interrupt/halt sequencer for the 65C02 core: arbitrates reset/NMI/IRQ/BRK at
// instruction boundaries and implements WAI/STP. Define INT_SEQ_SYNC_EN to synchronize irq/nmi.
module int_seq #(
    parameter logic [7:0] RESET_VEC = 8'hFC,
    parameter logic [7:0] NMI_VEC   = 8'hFA,
    parameter logic [7:0] IRQ_VEC   = 8'hFE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic       sync,
    input  logic       irq,
    input  logic       nmi,
    input  logic       I,
    input  logic       brk,
    input  logic       wai,
    input  logic       stp,
    output logic       take_int,
    output logic [7:0] vec_lo,
    output logic       B,
    output logic       halt,
    output logic       nmi_pend
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   rst_pend;
    logic   nmi1;
    logic   irq_s, nmi_s;

`ifdef INT_SEQ_SYNC_EN
    logic [1:0] irq_ff, nmi_ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_ff <= '0;
            nmi_ff <= '0;
        end else begin
            irq_ff <= {irq_ff[0], irq};
            nmi_ff <= {nmi_ff[0], nmi};
        end
    end

    assign irq_s = irq_ff[1];
    assign nmi_s = nmi_ff[1];
`else
    assign irq_s = irq;
    assign nmi_s = nmi;
`endif

    logic nmi_edge, irq_act, accept, wake, wake_now;
    logic sel_rst, sel_nmi, sel_irq, sel_brk;

    assign nmi_edge = nmi_s & ~nmi1;
    assign irq_act  = irq_s & ~I;
    assign accept   = sync & rdy & (state == S_RUN);
    assign take_int = sync & (state == S_RUN) & (rst_pend | nmi_pend | irq_act);
    assign halt     = (state != S_RUN);

    // WAIT resumes on a raw irq even when masked; an edge arriving with WAI also counts
    assign wake     = irq_s | nmi_pend;
    assign wake_now = wake | nmi_edge;

    always_comb begin
        sel_rst = 1'b0;
        sel_nmi = 1'b0;
        sel_irq = 1'b0;
        sel_brk = 1'b0;
        if (accept) begin
            if (rst_pend)      sel_rst = 1'b1;
            else if (nmi_pend) sel_nmi = 1'b1;
            else if (irq_act)  sel_irq = 1'b1;
            else if (brk)      sel_brk = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (rdy & stp)
                    state_nxt = S_STOP;
                else if (rdy & wai & ~wake_now)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (rdy & wake)
                    state_nxt = S_RUN;
            end
            S_STOP:  state_nxt = S_STOP;
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_RUN;
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi1     <= 1'b0;
            vec_lo   <= RESET_VEC;
            B        <= 1'b0;
        end else begin
            state <= state_nxt;
            nmi1  <= nmi_s;

            if (sel_rst)
                rst_pend <= 1'b0;

            // A fresh edge in the same cycle as the clear must not be lost
            if (nmi_edge)
                nmi_pend <= 1'b1;
            else if (sel_nmi)
                nmi_pend <= 1'b0;

            if (sel_rst) begin
                vec_lo <= RESET_VEC;
                B      <= 1'b0;
            end else if (sel_nmi) begin
                vec_lo <= NMI_VEC;
                B      <= 1'b0;
            end else if (sel_irq) begin
                vec_lo <= IRQ_VEC;
                B      <= 1'b0;
            end else if (sel_brk) begin
                vec_lo <= IRQ_VEC;
                B      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq (default build): expected outputs are queued
// as stimulus is applied and compared when the outputs are sampled.
module tb_int_seq;

    logic       clk = 1'b0;
    logic       reset, rdy, sync, irq, nmi, I, brk, wai, stp;
    logic       take_int, B, halt, nmi_pend;
    logic [7:0] vec_lo;

    int_seq #(
        .RESET_VEC(8'hFC),
        .NMI_VEC  (8'hFA),
        .IRQ_VEC  (8'hFE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rdy     (rdy),
        .sync    (sync),
        .irq     (irq),
        .nmi     (nmi),
        .I       (I),
        .brk     (brk),
        .wai     (wai),
        .stp     (stp),
        .take_int(take_int),
        .vec_lo  (vec_lo),
        .B       (B),
        .halt    (halt),
        .nmi_pend(nmi_pend)
    );

    always #5 clk = ~clk;

    typedef enum int { K_TAKE, K_VEC, K_B, K_HALT, K_NMIP } kind_t;
    typedef struct {
        string      tag;
        kind_t      kind;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input kind_t kind, input logic [7:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] observed(input kind_t kind);
        case (kind)
            K_TAKE:  return {7'd0, take_int};
            K_VEC:   return vec_lo;
            K_B:     return {7'd0, B};
            K_HALT:  return {7'd0, halt};
            default: return {7'd0, nmi_pend};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observed(e.kind), e.val);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rdy = 1'b1; sync = 1'b0; irq = 1'b0; nmi = 1'b0;
        I = 1'b1; brk = 1'b0; wai = 1'b0; stp = 1'b0;
        step(); step();

        // Reset state
        expect_out("rst_vec",   K_VEC,  8'hFC);
        expect_out("rst_B",     K_B,    8'h00);
        expect_out("rst_halt",  K_HALT, 8'h00);
        expect_out("rst_nmip",  K_NMIP, 8'h00);
        expect_out("rst_take0", K_TAKE, 8'h00);
        settle();

        // First boundary after reset takes the reset vector
        reset = 1'b0; sync = 1'b1;
        expect_out("rst_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("rst_acc_vec", K_VEC,  8'hFC);
        expect_out("rst_acc_B",   K_B,    8'h00);
        expect_out("idle_take",   K_TAKE, 8'h00);
        settle();

        // NMI edge with I=1, held high afterwards
        sync = 1'b0; nmi = 1'b1;
        step();
        expect_out("nmi_latched", K_NMIP, 8'h01);
        settle();
        sync = 1'b1;
        expect_out("nmi_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("nmi_vec",    K_VEC,  8'hFA);
        expect_out("nmi_clr",    K_NMIP, 8'h00);
        expect_out("nmi_level",  K_TAKE, 8'h00);
        settle();
        sync = 1'b0; nmi = 1'b0;
        step();

        // IRQ masked, then unmasked
        irq = 1'b1; sync = 1'b1;
        expect_out("irq_masked", K_TAKE, 8'h00);
        settle();
        step();
        expect_out("irq_masked_vec", K_VEC, 8'hFA);
        settle();
        I = 1'b0;
        expect_out("irq_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("irq_vec", K_VEC, 8'hFE);
        expect_out("irq_B",   K_B,   8'h00);
        settle();

        // IRQ and NMI both requesting: NMI wins
        sync = 1'b0; nmi = 1'b1;
        step();
        sync = 1'b1;
        expect_out("both_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("both_vec",  K_VEC,  8'hFA);
        expect_out("both_nmip", K_NMIP, 8'h00);
        settle();
        step();
        expect_out("irq_after_nmi", K_VEC, 8'hFE);
        settle();
        irq = 1'b0; nmi = 1'b0; sync = 1'b0;
        step();

        // BRK alone, then BRK under an active IRQ
        sync = 1'b1; brk = 1'b1;
        expect_out("brk_take", K_TAKE, 8'h00);
        settle();
        step();
        expect_out("brk_vec", K_VEC, 8'hFE);
        expect_out("brk_B",   K_B,   8'h01);
        settle();
        irq = 1'b1;
        expect_out("brk_irq_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("brk_irq_B", K_B, 8'h00);
        settle();
        irq = 1'b0; brk = 1'b0; sync = 1'b0; I = 1'b1;
        step();

        // WAI woken by masked IRQ: resume without taking it
        wai = 1'b1;
        step();
        wai = 1'b0;
        expect_out("wai_halt", K_HALT, 8'h01);
        settle();
        irq = 1'b1;
        step();
        expect_out("wai_wake_irq", K_HALT, 8'h00);
        settle();
        sync = 1'b1;
        expect_out("wai_no_take", K_TAKE, 8'h00);
        settle();
        step();
        sync = 1'b0; irq = 1'b0;

        // WAI ignored under rdy=0
        rdy = 1'b0; wai = 1'b1;
        step();
        expect_out("wai_nordy", K_HALT, 8'h00);
        settle();
        rdy = 1'b1; wai = 1'b0;

        // WAI coinciding with an NMI edge never halts
        wai = 1'b1; nmi = 1'b1;
        step();
        expect_out("wai_nmi_edge_halt", K_HALT, 8'h00);
        expect_out("wai_nmi_edge_pend", K_NMIP, 8'h01);
        settle();
        wai = 1'b0; nmi = 1'b0; sync = 1'b1;
        step();
        expect_out("wai_nmi_svc", K_VEC, 8'hFA);
        settle();
        sync = 1'b0;

        // WAI woken by a later NMI edge: pend latches, then wake next cycle
        wai = 1'b1;
        step();
        wai = 1'b0; nmi = 1'b1;
        step();
        expect_out("wai_nmi_still", K_HALT, 8'h01);
        expect_out("wai_nmi_pend",  K_NMIP, 8'h01);
        settle();
        step();
        expect_out("wai_nmi_wake", K_HALT, 8'h00);
        settle();
        sync = 1'b1; nmi = 1'b0;
        expect_out("wai_nmi_take", K_TAKE, 8'h01);
        settle();
        step();
        sync = 1'b0;

        // STP with WAI: stop wins; requests ignored, edges still latch
        stp = 1'b1; wai = 1'b1;
        step();
        stp = 1'b0; wai = 1'b0;
        expect_out("stp_halt", K_HALT, 8'h01);
        settle();
        for (int i = 0; i < 20; i++) begin
            irq = ~irq; nmi = ~nmi; sync = i[0];
            step();
        end
        expect_out("stp_held", K_HALT, 8'h01);
        expect_out("stp_nmip", K_NMIP, 8'h01);
        settle();
        sync = 1'b1; irq = 1'b1; I = 1'b0;
        expect_out("stp_no_take", K_TAKE, 8'h00);
        settle();
        irq = 1'b0; nmi = 1'b0; sync = 1'b0;

        // Asynchronous reset exits STOP and rearms the reset sequence
        reset = 1'b1;
        expect_out("stp_rst_halt", K_HALT, 8'h00);
        expect_out("stp_rst_nmip", K_NMIP, 8'h00);
        settle();
        step();
        reset = 1'b0; sync = 1'b1;
        expect_out("post_rst_take", K_TAKE, 8'h01);
        settle();
        step();
        expect_out("post_rst_vec", K_VEC, 8'hFC);
        expect_out("post_rst_B",   K_B,   8'h00);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
